ram_port_arbiter: RTL

Two-master arbiter and access sequencer for the single-port data RAM. It lets the CPU load/store path (master 0) share the RAM with a second requester (master 1), such as the program/debug loader or a future DMA/LED engine. It registers the winning request, holds the RAM for a configurable number of wait states, then returns a registered read word and a one-cycle `done` pulse. It also produces a stall signal that the CPU uses to gate its PC register while a data access is outstanding.

---
 rtl/ram_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-master round-robin arbiter and access sequencer for the data RAM
module ram_port_arbiter #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [2:0]        m0_mode,
    input  logic [31:0]       m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [2:0]        m1_mode,
    input  logic [31:0]       m1_wdata,
    output logic              m0_done,
    output logic [31:0]       m0_rdata,
    output logic              m0_stall,
    output logic              m1_done,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        ram_mode,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              gnt;
    logic              grant_valid;
    logic              grant_sel;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_mode;
    logic [31:0]       cmd_wdata;
    logic [3:0]        wait_cnt;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    // On a tie the master that did not win last time gets the grant.
    assign grant_valid = m0_req | m1_req;
    assign grant_sel   = (m0_req & m1_req) ? ~last_grant : m1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_en = 1'b1;
                // Write only in the final access cycle so each transaction commits once.
                if (wait_cnt == 4'd0) begin
                    ram_we    = cmd_we;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                m0_done   = ~gnt;
                m1_done   = gnt;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_mode   <= 3'd0;
            cmd_wdata  <= 32'd0;
            wait_cnt   <= 4'd0;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt        <= grant_sel;
                        last_grant <= grant_sel;
                        cmd_we     <= grant_sel ? m1_we    : m0_we;
                        cmd_addr   <= grant_sel ? m1_addr  : m0_addr;
                        cmd_mode   <= grant_sel ? m1_mode  : m0_mode;
                        cmd_wdata  <= grant_sel ? m1_wdata : m0_wdata;
                        wait_cnt   <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (gnt) begin
                        rdata1_q <= ram_rdata;
                    end else begin
                        rdata0_q <= ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_addr  = cmd_addr;
    assign ram_mode  = cmd_mode;
    assign ram_wdata = cmd_wdata;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign m0_stall  = m0_req & ~m0_done;

endmodule
